// File: rtl/matmul_sequencer_if.sv
// ============================================================================
// Module      : matmul_sequencer_if
// Description : Command/status and strobe bundle between the register file,
//               the matmul sequencer and the systolic datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matmul_sequencer_if #(
    parameter int MAX_DIM     = 4,
    parameter int SP_NTARGETS = 4
);
    localparam int DW = $clog2(MAX_DIM);
    localparam int TW = $clog2(SP_NTARGETS);

    logic          start_i;
    logic [DW-1:0] dim_n_i;
    logic [DW-1:0] dim_k_i;
    logic [DW-1:0] dim_m_i;
    logic          mode_acc_i;
    logic [TW-1:0] sp_src_i;
    logic [TW-1:0] sp_dst_i;

    logic          op_rd_en_o;
    logic [DW-1:0] op_rd_idx_o;
    logic          feed_valid_o;
    logic          pe_clear_o;
    logic          sp_rd_en_o;
    logic          sp_wr_en_o;
    logic [DW-1:0] sp_row_o;
    logic [TW-1:0] sp_target_o;
    logic          busy_o;
    logic          done_o;
    logic          start_err_o;

    modport master (
        output start_i, dim_n_i, dim_k_i, dim_m_i, mode_acc_i, sp_src_i, sp_dst_i,
        input  op_rd_en_o, op_rd_idx_o, feed_valid_o, pe_clear_o, sp_rd_en_o,
               sp_wr_en_o, sp_row_o, sp_target_o, busy_o, done_o, start_err_o
    );

    modport slave (
        input  start_i, dim_n_i, dim_k_i, dim_m_i, mode_acc_i, sp_src_i, sp_dst_i,
        output op_rd_en_o, op_rd_idx_o, feed_valid_o, pe_clear_o, sp_rd_en_o,
               sp_wr_en_o, sp_row_o, sp_target_o, busy_o, done_o, start_err_o
    );
endinterface

`default_nettype wire

// File: rtl/matmul_sequencer.sv
// ============================================================================
// Module      : matmul_sequencer
// Description : Control FSM for one matrix multiply: PE clear, operand feed,
//               systolic drain and scratchpad write-back (optional accumulate).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_sequencer #(
    parameter int BUS_WIDTH   = 16,
    parameter int MAX_DIM     = 4,
    parameter int SP_NTARGETS = 4
) (
    input  wire logic        clk_i,
    input  wire logic        rst_ni,
    matmul_sequencer_if.slave bus
);
    localparam int DW = $clog2(MAX_DIM);
    localparam int TW = $clog2(SP_NTARGETS);

    if (BUS_WIDTH < 1 || MAX_DIM < 2 || SP_NTARGETS < 2) begin : g_param_check
        $error("matmul_sequencer: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t        r_state;
    logic [DW-1:0] r_dim_n;
    logic [DW-1:0] r_dim_k;
    logic [DW-1:0] r_dim_m;
    logic          r_acc;
    logic [TW-1:0] r_src;
    logic [TW-1:0] r_dst;
    logic [DW:0]   r_drain_cnt;

    logic          r_op_rd_en;
    logic [DW-1:0] r_op_idx;
    logic          r_feed_valid;
    logic          r_pe_clear;
    logic          r_sp_rd_en;
    logic          r_sp_wr_en;
    logic [DW-1:0] r_sp_row;
    logic [TW-1:0] r_sp_target;
    logic          r_busy;
    logic          r_done;
    logic          r_start_err;

    // Last drain count is n+m-1 = dim_n + dim_m + 1 in minus-one encoding.
    logic [DW:0]   w_drain_last;
    assign w_drain_last = {1'b0, r_dim_n} + {1'b0, r_dim_m} + 1'b1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_dim_n      <= '0;
            r_dim_k      <= '0;
            r_dim_m      <= '0;
            r_acc        <= 1'b0;
            r_src        <= '0;
            r_dst        <= '0;
            r_drain_cnt  <= '0;
            r_op_rd_en   <= 1'b0;
            r_op_idx     <= '0;
            r_feed_valid <= 1'b0;
            r_pe_clear   <= 1'b0;
            r_sp_rd_en   <= 1'b0;
            r_sp_wr_en   <= 1'b0;
            r_sp_row     <= '0;
            r_sp_target  <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_start_err  <= 1'b0;
        end else begin
            r_feed_valid <= r_op_rd_en;

            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_dim_n     <= bus.dim_n_i;
                        r_dim_k     <= bus.dim_k_i;
                        r_dim_m     <= bus.dim_m_i;
                        r_acc       <= bus.mode_acc_i;
                        r_src       <= bus.sp_src_i;
                        r_dst       <= bus.sp_dst_i;
                        r_done      <= 1'b0;
                        r_start_err <= 1'b0;
                        r_busy      <= 1'b1;
                        r_pe_clear  <= 1'b1;
                        r_state     <= S_CLEAR;
                    end
                end

                S_CLEAR: begin
                    r_pe_clear <= 1'b0;
                    r_op_rd_en <= 1'b1;
                    r_op_idx   <= '0;
                    r_state    <= S_FEED;
                end

                S_FEED: begin
                    if (r_op_idx == r_dim_k) begin
                        r_op_rd_en  <= 1'b0;
                        r_op_idx    <= '0;
                        r_drain_cnt <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_op_idx <= r_op_idx + 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (r_drain_cnt == w_drain_last) begin
                        r_state  <= S_WRITE;
                        r_sp_row <= '0;
                        if (r_acc) begin
                            r_sp_rd_en  <= 1'b1;
                            r_sp_target <= r_src;
                        end else begin
                            r_sp_wr_en  <= 1'b1;
                            r_sp_target <= r_dst;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end

                S_WRITE: begin
                    if (r_sp_rd_en) begin
                        // Second half of an accumulate row: write the sum back.
                        r_sp_rd_en  <= 1'b0;
                        r_sp_wr_en  <= 1'b1;
                        r_sp_target <= r_dst;
                    end else if (r_sp_row == r_dim_n) begin
                        r_sp_wr_en  <= 1'b0;
                        r_sp_row    <= '0;
                        r_sp_target <= '0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_sp_row <= r_sp_row + 1'b1;
                        if (r_acc) begin
                            r_sp_wr_en  <= 1'b0;
                            r_sp_rd_en  <= 1'b1;
                            r_sp_target <= r_src;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase

            if (r_state != S_IDLE && bus.start_i) begin
                r_start_err <= 1'b1;
            end
        end
    end

    assign bus.op_rd_en_o   = r_op_rd_en;
    assign bus.op_rd_idx_o  = r_op_idx;
    assign bus.feed_valid_o = r_feed_valid;
    assign bus.pe_clear_o   = r_pe_clear;
    assign bus.sp_rd_en_o   = r_sp_rd_en;
    assign bus.sp_wr_en_o   = r_sp_wr_en;
    assign bus.sp_row_o     = r_sp_row;
    assign bus.sp_target_o  = r_sp_target;
    assign bus.busy_o       = r_busy;
    assign bus.done_o       = r_done;
    assign bus.start_err_o  = r_start_err;

endmodule

`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
// ============================================================================
// Module      : tb_matmul_sequencer
// Description : Randomized self-checking bench for matmul_sequencer against a
//               cycle-indexed timeline model of one operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_sequencer;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    matmul_sequencer_if u_if ();

    matmul_sequencer u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {busy, clr, rd, idx[1:0], fv, sprd, spwr, row[1:0], tgt[1:0], done}
    function automatic logic [12:0] obs_vec();
        return {u_if.busy_o, u_if.pe_clear_o, u_if.op_rd_en_o, u_if.op_rd_idx_o,
                u_if.feed_valid_o, u_if.sp_rd_en_o, u_if.sp_wr_en_o, u_if.sp_row_o,
                u_if.sp_target_o, u_if.done_o};
    endfunction

    // Expected outputs in cycle c, counting the cycle after the start edge as 1.
    function automatic logic [12:0] exp_vec(input int c, input int n, input int k,
                                            input int m, input bit acc,
                                            input int src, input int dst);
        int   len;
        int   ws;
        int   w;
        logic busy, clr, rd, fv, sprd, spwr, done;
        logic [1:0] idx, row, tgt;
        len  = 1 + k + n + m + (acc ? 2 * n : n);
        ws   = 2 + k + n + m;
        busy = (c >= 1 && c <= len);
        clr  = (c == 1);
        rd   = (c >= 2 && c <= k + 1);
        idx  = rd ? 2'(c - 2) : 2'd0;
        fv   = (c >= 3 && c <= k + 2);
        sprd = 1'b0;
        spwr = 1'b0;
        row  = 2'd0;
        tgt  = 2'd0;
        if (c >= ws && c <= len) begin
            w = c - ws;
            if (acc) begin
                sprd = (w % 2 == 0);
                spwr = !sprd;
                row  = 2'(w / 2);
                tgt  = sprd ? 2'(src) : 2'(dst);
            end else begin
                spwr = 1'b1;
                row  = 2'(w);
                tgt  = 2'(dst);
            end
        end
        done = (c > len);
        return {busy, clr, rd, idx, fv, sprd, spwr, row, tgt, done};
    endfunction

    task automatic drive_cmd(input int n, input int k, input int m, input bit acc,
                             input int src, input int dst);
        u_if.dim_n_i    = 2'(n - 1);
        u_if.dim_k_i    = 2'(k - 1);
        u_if.dim_m_i    = 2'(m - 1);
        u_if.mode_acc_i = acc;
        u_if.sp_src_i   = 2'(src);
        u_if.sp_dst_i   = 2'(dst);
    endtask

    // inj: cycle in which a stray start is driven (0 = none);
    // chg: cycle in which the command inputs are scrambled (0 = none).
    task automatic run_op(input int n, input int k, input int m, input bit acc,
                          input int src, input int dst, input int inj, input int chg);
        int len;
        len = 1 + k + n + m + (acc ? 2 * n : n);
        drive_cmd(n, k, m, acc, src, dst);
        u_if.start_i = 1'b1;
        @(posedge clk);
        #1 u_if.start_i = 1'b0;
        for (int c = 1; c <= len + 1; c++) begin
            @(negedge clk);
            chk($sformatf("cyc%0d", c), 32'(obs_vec()), 32'(exp_vec(c, n, k, m, acc, src, dst)));
            chk($sformatf("err%0d", c), 32'(u_if.start_err_o), 32'(inj > 0 && c > inj));
            if (c == chg) begin
                drive_cmd($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
                          1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
            end
            if (c == inj) begin
                u_if.start_i = 1'b1;
                @(posedge clk);
                #1 u_if.start_i = 1'b0;
            end
        end
    endtask

    initial begin
        int n, k, m, len, inj;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        u_if.start_i = 1'b0;
        drive_cmd(1, 1, 1, 1'b0, 0, 0);

        #3 chk("rst_init", 32'({obs_vec(), u_if.start_err_o}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1, 1, 1, 1'b0, 0, 1, 0, 0);
        run_op(4, 4, 4, 1'b0, 0, 2, 0, 0);
        run_op(2, 3, 1, 1'b1, 1, 3, 0, 0);
        run_op(3, 2, 2, 1'b0, 0, 1, 5, 0);
        run_op(2, 4, 3, 1'b1, 2, 0, 0, 3);

        // Abort a 4x4x4 operation during FEED with an off-edge reset.
        drive_cmd(4, 4, 4, 1'b0, 0, 2);
        u_if.start_i = 1'b1;
        @(posedge clk);
        #1 u_if.start_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 32'({obs_vec(), u_if.start_err_o}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_hold", 32'({obs_vec(), u_if.start_err_o}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst", 32'({obs_vec(), u_if.start_err_o}), 32'd0);
        run_op(1, 1, 1, 1'b0, 0, 3, 0, 0);

        for (int t = 0; t < 30; t++) begin
            n   = $urandom_range(1, 4);
            k   = $urandom_range(1, 4);
            m   = $urandom_range(1, 4);
            len = 1 + k + n + m + 2 * n;
            inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 1 + k + n + m) : 0;
            run_op(n, k, m, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                   $urandom_range(0, 3), (inj < len) ? inj : 0, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
